id_ex_skid: RTL and testbench

ID_EX_SKID -- requirements
Module: id_ex_skid

---
 rtl/id_ex_skid.sv | 103 ++++++++++
 tb/tb_id_ex_skid.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid.sv
// Two-entry in-order skid buffer between the decode and execute stages.
// The main entry drives ex; the skid entry absorbs one extra instruction so in_ready_o depends only on registered state.
`timescale 1ns/1ps
module id_ex_skid #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic [31:0] op1_i,
   input  logic [31:0] op2_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        rd_wen_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic        flush_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] op1_o,
   output logic [31:0] op2_o,
   output logic [4:0]  rd_addr_o,
   output logic        rd_wen_o,
   output logic        out_valid_o,
   input  logic        out_ready_i
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd_addr;
      logic        rd_wen;
   } entry_t;

   state_t r_state;
   entry_t r_main;
   entry_t r_skid;
   entry_t w_in;
   logic   w_in_fire;
   logic   w_out_fire;

   assign w_in = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, rd_wen_i};

   assign in_ready_o  = (r_state != S_FULL);
   assign out_valid_o = (r_state != S_EMPTY);
   assign w_in_fire   = in_valid_i & in_ready_o;
   assign w_out_fire  = out_valid_o & out_ready_i;

   // Flush wins over both handshakes: whatever was offered or consumed this cycle is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else if (flush_i) begin
         r_state <= S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  r_main  <= w_in;
                  r_state <= S_ONE;
               end
            end
            S_ONE: begin
               case ({w_in_fire, w_out_fire})
                  2'b11: r_main <= w_in;
                  2'b10: begin
                     r_skid  <= w_in;
                     r_state <= S_FULL;
                  end
                  2'b01: r_state <= S_EMPTY;
                  default: r_state <= S_ONE;
               endcase
            end
            S_FULL: begin
               if (w_out_fire) begin
                  r_main  <= r_skid;
                  r_state <= S_ONE;
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   // Stale main contents stay hidden behind a NOP whenever nothing valid is held.
   assign inst_o      = out_valid_o ? r_main.inst    : NOP_INST;
   assign inst_addr_o = out_valid_o ? r_main.addr    : 32'd0;
   assign op1_o       = out_valid_o ? r_main.op1     : 32'd0;
   assign op2_o       = out_valid_o ? r_main.op2     : 32'd0;
   assign rd_addr_o   = out_valid_o ? r_main.rd_addr : 5'd0;
   assign rd_wen_o    = out_valid_o ? r_main.rd_wen  : 1'b0;

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed scenarios then random traffic, checked against a queue model of the buffer.
`timescale 1ns/1ps
module tb_id_ex_skid;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        wen;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, out_ready, flush;
   ent_t        cur;
   logic        in_ready_o, out_valid_o, rd_wen_o;
   logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
   logic [4:0]  rd_addr_o;

   ent_t q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   id_ex_skid #(.NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .rst(rst),
      .inst_i(cur.inst), .inst_addr_i(cur.addr), .op1_i(cur.op1), .op2_i(cur.op2),
      .rd_addr_i(cur.rd), .rd_wen_i(cur.wen),
      .in_valid_i(in_valid), .in_ready_o(in_ready_o), .flush_i(flush),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
      .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready)
   );

   function automatic ent_t rand_ent();
      ent_t e;
      e.inst = $urandom;
      e.addr = $urandom;
      e.op1  = $urandom;
      e.op2  = $urandom;
      e.rd   = 5'($urandom_range(0, 31));
      e.wen  = 1'($urandom_range(0, 1));
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected outputs follow directly from the queue: head entry if any, NOP otherwise.
   task automatic check_all(input string tag);
      ent_t e;
      e = '0;
      e.inst = 32'h0000_0013;
      if (q.size() > 0) e = q[0];
      chk({tag, ".out_valid"}, 32'(out_valid_o), 32'(q.size() > 0));
      chk({tag, ".in_ready"},  32'(in_ready_o),  32'(q.size() < 2));
      chk({tag, ".inst"},      inst_o,           e.inst);
      chk({tag, ".inst_addr"}, inst_addr_o,      e.addr);
      chk({tag, ".op1"},       op1_o,            e.op1);
      chk({tag, ".op2"},       op2_o,            e.op2);
      chk({tag, ".rd_addr"},   32'(rd_addr_o),   32'(e.rd));
      chk({tag, ".rd_wen"},    32'(rd_wen_o),    32'(e.wen));
   endtask

   task automatic step(input string tag);
      bit in_fire, out_fire;
      in_fire  = rst && in_valid && (q.size() < 2);
      out_fire = rst && out_ready && (q.size() > 0);
      @(posedge clk);
      #1;
      if (!rst || flush) begin
         q.delete();
      end else begin
         if (out_fire) void'(q.pop_front());
         if (in_fire) q.push_back(cur);
      end
      check_all(tag);
   endtask

   initial begin
      ent_t a, b;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; cur = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // Single instruction, latency one cycle
      cur = '0; cur.inst = 32'h0050_0093; cur.addr = 32'h10; cur.op1 = 32'h5; cur.rd = 5'd1; cur.wen = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      step("first");
      in_valid = 1'b0;
      step("first_drain");

      // Fill to FULL with ex stalled, then drain A then B
      a = rand_ent(); b = rand_ent();
      out_ready = 1'b0; in_valid = 1'b1; cur = a;
      step("fill_a");
      cur = b;
      step("fill_b");
      step("full_hold");
      in_valid = 1'b0; out_ready = 1'b1;
      step("pop_a");
      step("pop_b");

      // Back-to-back stream never fills the skid entry
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cur = rand_ent();
         step("stream");
      end
      in_valid = 1'b0;
      step("stream_drain");

      // Flush while FULL drops the offered instruction C
      out_ready = 1'b0; in_valid = 1'b1;
      cur = rand_ent(); step("pre_flush1");
      cur = rand_ent(); step("pre_flush2");
      cur = rand_ent(); cur.wen = 1'b1; flush = 1'b1;
      step("flush");
      flush = 1'b0; in_valid = 1'b0;
      step("post_flush");

      // Asynchronous reset while ONE holds address 0x20
      cur = rand_ent(); cur.addr = 32'h20; in_valid = 1'b1;
      step("load_20");
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      q.delete();
      check_all("async_rst");
      in_valid = 1'b1; cur = rand_ent();
      @(negedge clk);
      step("rst_hold");
      rst = 1'b1; cur = rand_ent();
      step("first_after_rst");
      in_valid = 1'b0; out_ready = 1'b1;
      step("drain_after_rst");

      // Random traffic; also probe that in_ready_o ignores out_ready_i within the cycle
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         out_ready = ($urandom_range(0, 99) < 60);
         flush     = ($urandom_range(0, 99) < 4);
         cur       = rand_ent();
         #1;
         chk("comb_ready", 32'(in_ready_o), 32'(q.size() < 2));
         out_ready = ~out_ready;
         #1;
         chk("comb_ready_toggled", 32'(in_ready_o), 32'(q.size() < 2));
         out_ready = ~out_ready;
         step("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
